// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter and ownership controller for a shared 4-way resource.
// Optional macro RR_GRANT_LOCK_EN adds a lock input that suppresses the hold-limit release.
module rr_grant_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
`ifdef RR_GRANT_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_grant;
    logic [1:0]    r_idx;
    logic          r_busy;
    logic          r_timeout;

    logic [1:0]    w_sel;
    logic [1:0]    w_cand;
    logic          w_found;
    logic          w_at_limit;
    logic          w_limit_rel;
    logic          w_owner_req;
    logic          w_release;
    logic          w_forced;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps modulo 4 for free.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_at_limit = (r_hold == HW'(MAX_HOLD));
`ifdef RR_GRANT_LOCK_EN
    assign w_limit_rel = w_at_limit && !lock;
`else
    assign w_limit_rel = w_at_limit;
`endif
    assign w_owner_req = req[r_idx];
    assign w_release   = done || !w_owner_req || w_limit_rel;
    assign w_forced    = w_limit_rel && !done && w_owner_req;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_hold    <= '0;
            r_grant   <= 4'b0000;
            r_idx     <= 2'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_sel;
                        r_idx   <= w_sel;
                        r_busy  <= 1'b1;
                        r_hold  <= HW'(1);
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        r_grant   <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                        r_ptr     <= r_idx + 2'd1;
                        r_hold    <= '0;
                        r_timeout <= w_forced;
                    end else begin
                        r_timeout <= 1'b0;
                        // Saturate at the limit (only reachable while locked).
                        if (!w_at_limit) begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed vector table plus multi-cycle sequences.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       lock;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_ctrl #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
`ifdef RR_GRANT_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic b, input logic t);
        check({name, " grant"}, 8'(grant), 8'(g));
        check({name, " busy"}, 8'(busy), 8'(b));
        check({name, " timeout"}, 8'(timeout), 8'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fairness with done on the 2nd owned cycle, then ptr wrap and withdrawal.
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[11] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[12] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        lock = 1'b0;
        #12;
        check_out("reset", 4'b0000, 1'b0, 1'b0);
        check("reset grant_idx", 8'(grant_idx), 8'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].timeout);
            if (vecs[i].busy)
                check($sformatf("vec%0d grant_idx", i), 8'(grant_idx), 8'(vecs[i].idx));
        end
        done = 1'b0;

        // Forced release after exactly 8 owned cycles, then re-grant after one dead cycle.
        req = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            step();
            check_out($sformatf("hold cyc%0d", c + 1), 4'b0010, 1'b1, 1'b0);
        end
        step();
        check_out("forced release", 4'b0000, 1'b0, 1'b1);
        step();
        check_out("regrant after timeout", 4'b0010, 1'b1, 1'b0);
        check("regrant grant_idx", 8'(grant_idx), 8'd1);
        req = 4'b0000;
        step();
        check_out("withdraw after regrant", 4'b0000, 1'b0, 1'b0);
        step();

        // done coinciding with the 8th hold cycle is a normal release.
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            step();
            check_out($sformatf("coincide cyc%0d", c + 1), 4'b0001, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        check_out("done at limit", 4'b0000, 1'b0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        step();

        // Asynchronous reset while owner 2 holds with hold=3.
        req = 4'b0100;
        step();
        step();
        step();
        check_out("owner2 before reset", 4'b0100, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_out("async reset", 4'b0000, 1'b0, 1'b0);
        #3 rst = 1'b0;
        req = 4'b1111;
        step();
        check_out("after reset ptr0", 4'b0001, 1'b1, 1'b0);
        check("after reset grant_idx", 8'(grant_idx), 8'd0);
        req = 4'b0000;
        step();
        step();

`ifdef RR_GRANT_LOCK_EN
        lock = 1'b1;
        req  = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            step();
            check_out($sformatf("lock cyc%0d", c + 1), 4'b0001, 1'b1, 1'b0);
        end
        lock = 1'b0;
        step();
        check_out("lock drop release", 4'b0000, 1'b0, 1'b1);
        req = 4'b0000;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
Round-robin arbiter and ownership controller for a shared 4-way resource. Examples of such a resource are a mux4 select path or a shared counter.
- Accepts level requests from 4 requesters and issues a registered one-hot grant plus an encoded select.
- Holds the grant until the owner releases or a hold limit expires.
- Rotates priority so that no requester starves.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant before forced release (legal range 1..255)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
req  input  4  level request per requester; bit i = requester i
done  input  1  owner signals end of use; sampled only while busy=1
grant  output  4  registered one-hot grant; all-zero when no owner
grant_idx  output  2  encoded owner index; drives the shared mux select
busy  output  1  1 while any grant is active
timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD

Behaviour:
- Reset (asynchronous, rst=1):
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- State IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3, with wrap modulo 4.
  - Next edge: grant[sel]=1, grant_idx=sel, busy=1, hold counter=1, state=OWN.
  - Request-to-grant latency is 1 cycle.
  - If req=0, stay in IDLE with all outputs 0.
- State OWN, evaluated each edge with owner o:
  - Release if any of the following is true: done=1; req[o]=0; hold counter==MAX_HOLD.
  - On release:
    - Next edge: grant=0, busy=0, state=IDLE, ptr=(o+1) mod 4, hold counter=0.
    - grant_idx keeps the last owner value; it is don't-care while busy=0.
  - Otherwise, hold counter increments by 1 and the grant is unchanged.
- Forced release: when release occurs only because hold counter==MAX_HOLD (done=0 and req[o]=1), timeout=1 for exactly the cycle in which grant drops.
- Dead cycle: exactly one grant-free cycle (IDLE) separates consecutive owners. Back-to-back owners therefore see grant patterns like 0001, 0000, 0010.
- Grant width rules:
  - grant is always one-hot or zero, never multi-hot.
  - grant_idx equals the index of the set grant bit whenever busy=1.
- Hold counter: width is the minimum needed to hold MAX_HOLD. It is never compared above MAX_HOLD and never wraps.
- Simultaneous events:
  - done and the hold limit in the same cycle: treat as a normal release, timeout=0.
  - done while req of other requesters is pending: release first, then arbitrate in the following IDLE cycle using the advanced ptr.
- req changes from non-owners while in OWN are ignored until IDLE.
- done sampled in IDLE is ignored.
- Reset mid-ownership: grant drops immediately (asynchronously), and ptr returns to 0.

Optional Feature:
Macro RR_GRANT_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit), placed after done.
  - While in OWN with lock=1, the hold-limit release is suppressed and the hold counter saturates at MAX_HOLD.
  - done and req[o]=0 still release.
  - timeout can only fire once lock=0 and the counter is at MAX_HOLD.
- Not defined: no lock port, and hold-limit behaviour is exactly as in Behaviour.

Test Plan:
- Reset check: assert rst mid-grant (owner 2, hold=3) -> grant=0000, busy=0, timeout=0 immediately; after deassert, req=1111 -> grant=0001 one cycle later.
- Round-robin fairness: req=1111 held, each owner raises done on its 2nd owned cycle -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 with no skips.
- Priority pointer wrap: after owner 3 releases, req=0101 -> grant=0001 (ptr=0), then after release -> grant=0100.
- Forced release: MAX_HOLD=8, req=0010 held, done=0 -> grant=0010 for exactly 8 cycles, timeout=1 on the cycle grant drops, then re-grant 0010 after one dead cycle.
- Request withdrawal and simultaneous events: owner 1 drops req[1] -> grant=0 next cycle, timeout=0; done and the 8th hold cycle coincide -> timeout=0.
- With RR_GRANT_LOCK_EN defined: lock=1 for 12 cycles with req[0] held -> grant=0001 for 12 cycles with no timeout; lock drops -> release next edge with timeout=1.
